// File: rtl/addr8s_sum_checker.sv
// Purpose : bit-serial recovery of B = S - A for the 8-bit signed adder family; flags S values no legal B explains.
// Latency : accept at edge E0, ten SHIFT edges E1..E10, result valid after E10 (11 cycles minimum per operation).
// Backpress: single operation in flight; in_ready low while busy, result held in DONE until out_ready.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (in_ready = block idle)
//   s[8:0], a[7:0]      adder result and adder A operand, two's complement
//   out_valid/out_ready result handshake
//   d[9:0]              exact S - A, two's complement
//   range_err           d outside [-128, 127]
//
// Build option: define ADDR8S_CHK_RANGE_FLAG_EN to compute range_err; otherwise it is tied to 0.
module addr8s_sum_checker (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [8:0] s,
  input  logic [7:0] a,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [9:0] d,
  output logic       range_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [9:0] s_sr, a_sr, d_sr;
  logic       c;
  logic [3:0] cnt;

  logic       accept;
  logic       last;
  logic       bit_sum;
  logic       c_nxt;
  logic [9:0] d_nxt;

  // One full-adder cell: S + ~A + 1 evaluated LSB first, the +1 coming from c=1 at load.
  always_comb begin
    bit_sum = s_sr[0] ^ a_sr[0] ^ c;
    c_nxt   = (s_sr[0] & a_sr[0]) | (s_sr[0] & c) | (a_sr[0] & c);
    d_nxt   = {bit_sum, d_sr[9:1]};
    last    = (state == SHIFT) && (cnt == 4'd9);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake outputs, decoded from the state register only
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (cnt == 4'd9) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = in_valid && in_ready;

  // Serial datapath. d is a separate register so the result stays put after DONE
  // while d_sr is free to be reused by the next operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_sr <= 10'd0;
      a_sr <= 10'd0;
      d_sr <= 10'd0;
      c    <= 1'b0;
      cnt  <= 4'd0;
      d    <= 10'd0;
    end else begin
      if (accept) begin
        s_sr <= {s[8], s};
        a_sr <= ~{{2{a[7]}}, a};
        c    <= 1'b1;
        cnt  <= 4'd0;
      end else if (state == SHIFT) begin
        s_sr <= {1'b0, s_sr[9:1]};
        a_sr <= {1'b0, a_sr[9:1]};
        d_sr <= d_nxt;
        c    <= c_nxt;
        cnt  <= cnt + 4'd1;
      end
      if (last) begin
        d <= d_nxt;
      end
    end
  end

`ifdef ADDR8S_CHK_RANGE_FLAG_EN
  // Legal 8-bit values have bits 9..7 all equal (pure sign extension).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      range_err <= 1'b0;
    end else if (last) begin
      range_err <= ~((d_nxt[9:7] == 3'b000) || (d_nxt[9:7] == 3'b111));
    end
  end
`else
  assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_addr8s_sum_checker.sv
module tb_addr8s_sum_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] s;
  logic [7:0] a;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] d;
  logic       range_err;

  int   n_chk = 0;
  int   n_fail = 0;
  logic pending = 1'b0;
  logic [9:0] exp_d = 10'd0;
  logic exp_re = 1'b0;

`ifdef ADDR8S_CHK_RANGE_FLAG_EN
  localparam bit RE_EN = 1'b1;
`else
  localparam bit RE_EN = 1'b0;
`endif

  addr8s_sum_checker dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s         (s),
    .a         (a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .range_err (range_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain signed integer subtraction
  function automatic int model_x(input logic [8:0] si, input logic [7:0] ai);
    int sv;
    int av;
    sv = int'($signed(si));
    av = int'($signed(ai));
    return sv - av;
  endfunction

  function automatic logic [9:0] model_d(input logic [8:0] si, input logic [7:0] ai);
    int x;
    x = model_x(si, ai);
    return x[9:0];
  endfunction

  function automatic logic model_re(input logic [8:0] si, input logic [7:0] ai);
    int x;
    x = model_x(si, ai);
    return RE_EN && ((x < -128) || (x > 127));
  endfunction

  // Output checker: whenever a result is presented it must match the model
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      check("out_pending", {31'd0, pending}, 32'd1);
      check("out_d", {22'd0, d}, {22'd0, exp_d});
      check("out_range_err", {31'd0, range_err}, {31'd0, exp_re});
      check("out_ready_excl", {31'd0, in_ready}, 32'd0);
    end
  end

  task automatic run_op(input logic [8:0] si, input logic [7:0] ai, input int hold);
    int k;
    k = 0;
    while (in_ready !== 1'b1 && k < 50) begin
      @(posedge clk); #1; k++;
    end
    check("idle_wait", {31'd0, in_ready}, 32'd1);
    s = si;
    a = ai;
    in_valid = 1'b1;
    out_ready = (hold == 0);
    exp_d = model_d(si, ai);
    exp_re = model_re(si, ai);
    @(posedge clk);
    pending = 1'b1;
    #1;
    in_valid = 1'b0;
    s = 9'($urandom);
    a = 8'($urandom);
    k = 0;
    while (out_valid !== 1'b1 && k < 30) begin
      check("busy_in_ready", {31'd0, in_ready}, 32'd0);
      // traffic while busy must be ignored
      in_valid = 1'($urandom_range(0, 1));
      s = 9'($urandom);
      a = 8'($urandom);
      @(posedge clk); #1; k++;
    end
    check("latency", k, 32'd10);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      s = 9'($urandom);
      a = 8'($urandom);
      @(posedge clk); #1;
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    pending = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("post_hs_valid", {31'd0, out_valid}, 32'd0);
    check("post_hs_ready", {31'd0, in_ready}, 32'd1);
    check("held_d", {22'd0, d}, {22'd0, exp_d});
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int seen;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    s = 9'd0;
    a = 8'd0;
    #12;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_d", {22'd0, d}, 32'd0);
    check("rst_range_err", {31'd0, range_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases with hand-computed results
    run_op(9'h00A, 8'h03, 0);
    check("lit_d_10m3", {22'd0, d}, 32'h007);
    check("lit_re_10m3", {31'd0, range_err}, 32'd0);
    run_op(9'h180, 8'h7F, 0);
    check("lit_d_m128m127", {22'd0, d}, 32'h301);
    check("lit_re_m128m127", {31'd0, range_err}, RE_EN ? 32'd1 : 32'd0);
    run_op(9'h1FE, 8'hFF, 0);
    check("lit_d_m2pm1", {22'd0, d}, 32'h3FF);
    check("lit_re_m2pm1", {31'd0, range_err}, 32'd0);
    run_op(9'h0FE, 8'h7F, 0);
    check("lit_d_254m127", {22'd0, d}, 32'h07F);
    check("lit_re_254m127", {31'd0, range_err}, 32'd0);

    // Backpressure: five cycles of out_ready low with new operands offered
    run_op(9'h180, 8'h7F, 5);
    check("lit_d_bp", {22'd0, d}, 32'h301);
    run_op(9'h0FF, 8'h80, 0);
    check("lit_d_255p128", {22'd0, d}, 32'h17F);

    // Reset during the 4th SHIFT cycle aborts the operation
    s = 9'h155;
    a = 8'h2A;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_d", {22'd0, d}, 32'd0);
    check("abort_range_err", {31'd0, range_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    check("abort_no_result", seen, 32'd0);
    run_op(9'h010, 8'h01, 0);
    check("lit_d_after_abort", {22'd0, d}, 32'h00F);

    // Randomized operands and backpressure against the model
    for (int n = 0; n < 40; n++) begin
      run_op(9'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
